// File: rtl/wb_burst_manager_if.sv
// Classic Wishbone bus between the burst manager (master) and a slave or arbiter.
interface wb_burst_manager_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   ADR_O;
  logic [DATA_W-1:0]   DAT_O;
  logic [DATA_W/8-1:0] SEL_O;
  logic                WE_O;
  logic                STB_O;
  logic                CYC_O;
  logic [DATA_W-1:0]   DAT_I;
  logic                ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/wb_burst_manager.sv
// Turns one CPU command into a 1..MAX_BURST beat classic Wishbone cycle with
// incrementing addresses, streamed write/read data and an ACK watchdog.
module wb_burst_manager #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64,
  localparam int LEN_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                WRITE_I,
  input  logic                READ_I,
  input  logic [ADDR_W-1:0]   ADR_I,
  input  logic [DATA_W/8-1:0] SEL_I,
  input  logic [LEN_W-1:0]    LEN_I,
  input  logic [DATA_W-1:0]   CPU_DAT_I,
  input  logic                WDAT_VALID_I,
  output logic                WDAT_READY_O,
  output logic [DATA_W-1:0]   CPU_DAT_O,
  output logic                RDAT_VALID_O,
  output logic                BUSY_O,
  output logic                DONE_O,
  output logic                ERR_O,
  wb_burst_manager_if.master  wb
);

  localparam int TIM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIM_W-1:0]  TIM_LAST = TIM_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    STROBE,
    GAP,
    FINISH
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] len;
  logic [TIM_W-1:0] timer;

  // Pulse outputs default low every cycle; WE_O doubles as the burst direction.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      beat         <= '0;
      len          <= '0;
      timer        <= '0;
      WDAT_READY_O <= 1'b0;
      CPU_DAT_O    <= '0;
      RDAT_VALID_O <= 1'b0;
      BUSY_O       <= 1'b0;
      DONE_O       <= 1'b0;
      ERR_O        <= 1'b0;
      wb.ADR_O     <= '0;
      wb.DAT_O     <= '0;
      wb.SEL_O     <= '0;
      wb.WE_O      <= 1'b0;
      wb.STB_O     <= 1'b0;
      wb.CYC_O     <= 1'b0;
    end else begin
      RDAT_VALID_O <= 1'b0;
      DONE_O       <= 1'b0;
      ERR_O        <= 1'b0;

      unique case (state)
        IDLE: begin
          if (WRITE_I || READ_I) begin
            wb.ADR_O <= ADR_I;
            wb.SEL_O <= SEL_I;
            wb.WE_O  <= WRITE_I;
            len      <= LEN_I;
            beat     <= '0;
            timer    <= '0;
            BUSY_O   <= 1'b1;
            if (WRITE_I) begin
              WDAT_READY_O <= 1'b1;
              state        <= WDATA;
            end else begin
              wb.CYC_O <= 1'b1;
              wb.STB_O <= 1'b1;
              state    <= STROBE;
            end
          end
        end

        WDATA: begin
          if (WDAT_VALID_I) begin
            wb.DAT_O     <= CPU_DAT_I;
            WDAT_READY_O <= 1'b0;
            wb.CYC_O     <= 1'b1;
            wb.STB_O     <= 1'b1;
            state        <= STROBE;
          end
        end

        STROBE: begin
          // An ACK in the watchdog's final cycle still completes the beat.
          if (wb.ACK_I) begin
            timer    <= '0;
            wb.STB_O <= 1'b0;
            if (!wb.WE_O) begin
              CPU_DAT_O    <= wb.DAT_I;
              RDAT_VALID_O <= 1'b1;
            end
            if (beat == len) begin
              state <= FINISH;
            end else begin
              beat     <= beat + 1'b1;
              wb.ADR_O <= wb.ADR_O + ADR_STEP;
              if (wb.WE_O) begin
                WDAT_READY_O <= 1'b1;
                state        <= WDATA;
              end else begin
                state <= GAP;
              end
            end
          end else if ((TIMEOUT != 0) && (timer == TIM_LAST)) begin
            timer    <= '0;
            wb.CYC_O <= 1'b0;
            wb.STB_O <= 1'b0;
            wb.WE_O  <= 1'b0;
            BUSY_O   <= 1'b0;
            ERR_O    <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          wb.STB_O <= 1'b1;
          state    <= STROBE;
        end

        FINISH: begin
          wb.CYC_O <= 1'b0;
          wb.WE_O  <= 1'b0;
          BUSY_O   <= 1'b0;
          DONE_O   <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_manager.sv
// Bench for wb_burst_manager: directed bursts plus random bursts compared
// against a transaction-level expectation of addresses, data and cycle counts.
module tb_wb_burst_manager;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 8;
  localparam int BOUND     = 400;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        WRITE_I = 1'b0;
  logic        READ_I = 1'b0;
  logic [31:0] ADR_I = '0;
  logic [3:0]  SEL_I = '0;
  logic [3:0]  LEN_I = '0;
  logic [31:0] CPU_DAT_I = '0;
  logic        WDAT_VALID_I = 1'b0;
  logic        WDAT_READY_O;
  logic [31:0] CPU_DAT_O;
  logic        RDAT_VALID_O;
  logic        BUSY_O;
  logic        DONE_O;
  logic        ERR_O;

  wb_burst_manager_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_burst_manager #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .WRITE_I(WRITE_I), .READ_I(READ_I), .ADR_I(ADR_I), .SEL_I(SEL_I),
    .LEN_I(LEN_I), .CPU_DAT_I(CPU_DAT_I), .WDAT_VALID_I(WDAT_VALID_I),
    .WDAT_READY_O(WDAT_READY_O), .CPU_DAT_O(CPU_DAT_O),
    .RDAT_VALID_O(RDAT_VALID_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O),
    .ERR_O(ERR_O), .wb(bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail = 0;

  int          slave_wait = 0;
  bit          slave_mute = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] rd_q[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic [3:0]  log_sel[$];
  logic        log_we[$];

  int          done_cnt = 0;
  int          err_cnt = 0;
  int          ack_cnt = 0;
  int          stb_cycles = 0;
  int          gap_cycles = 0;
  logic [31:0] rdat_q[$];

  logic [31:0] wd_list[$];
  logic [31:0] rd_list[$];
  int          done0;
  int          err0;
  bit          timed_out;

  // Slave: acknowledges each strobe after slave_wait wait states, logging the beat.
  initial begin
    bus.ACK_I = 1'b0;
    bus.DAT_I = '0;
    forever begin
      @(negedge wb_clk_i);
      bus.ACK_I = 1'b0;
      if (!wb_rst_i && bus.CYC_O && bus.STB_O && !slave_mute) begin
        if (wait_cnt >= slave_wait) begin
          wait_cnt  = 0;
          bus.ACK_I = 1'b1;
          if (rd_q.size() > 0) bus.DAT_I = rd_q.pop_front();
          else bus.DAT_I = 32'hDEAD_BEEF;
          log_adr.push_back(bus.ADR_O);
          log_dat.push_back(bus.DAT_O);
          log_sel.push_back(bus.SEL_O);
          log_we.push_back(bus.WE_O);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (DONE_O) done_cnt++;
      if (ERR_O) err_cnt++;
      if (RDAT_VALID_O) rdat_q.push_back(CPU_DAT_O);
      if (bus.STB_O) stb_cycles++;
      if (bus.CYC_O && !bus.STB_O) gap_cycles++;
      if (bus.ACK_I) ack_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_write, input logic [31:0] adr, input logic [3:0] sel,
                               input int len, input int wait_st, input int stall_beat,
                               input int stall_cycles);
    int wbeat;
    int stall_left;
    int cyc;
    wbeat      = 0;
    stall_left = stall_cycles;
    cyc        = 0;
    slave_wait = wait_st;
    rd_q       = rd_list;
    log_adr.delete();
    log_dat.delete();
    log_sel.delete();
    log_we.delete();
    rdat_q.delete();
    stb_cycles = 0;
    gap_cycles = 0;
    done0      = done_cnt;
    err0       = err_cnt;
    @(negedge wb_clk_i);
    WRITE_I = is_write;
    READ_I  = !is_write;
    ADR_I   = adr;
    SEL_I   = sel;
    LEN_I   = 4'(len);
    @(negedge wb_clk_i);
    WRITE_I = 1'b0;
    READ_I  = 1'b0;
    while (done_cnt == done0 && err_cnt == err0 && cyc < BOUND) begin
      if (WDAT_VALID_I) begin
        WDAT_VALID_I = 1'b0;
        wbeat++;
      end
      if (is_write && WDAT_READY_O && wbeat <= len) begin
        if (wbeat == stall_beat && stall_left > 0) begin
          stall_left--;
        end else begin
          WDAT_VALID_I = 1'b1;
          CPU_DAT_I    = wd_list[wbeat];
        end
      end
      @(negedge wb_clk_i);
      cyc++;
    end
    WDAT_VALID_I = 1'b0;
    timed_out    = (cyc >= BOUND);
    repeat (3) @(negedge wb_clk_i);
  endtask

  // Expected beats follow start + 4*i (mod 2^32); STB time is (wait+1) per beat;
  // CYC-high/STB-low time is one cycle per inter-beat slot, any stall, and the closing cycle.
  task automatic checkBurst(input string name, input bit is_write, input logic [31:0] adr,
                            input logic [3:0] sel, input int len, input int wait_st,
                            input int stall_beat, input int stall_cycles);
    int exp_gap;
    checkOutput({name, "_bound"}, 32'(timed_out), 0);
    checkOutput({name, "_done"}, done_cnt - done0, 1);
    checkOutput({name, "_err"}, err_cnt - err0, 0);
    checkOutput({name, "_busy"}, 32'(BUSY_O), 0);
    checkOutput({name, "_cyc"}, 32'(bus.CYC_O), 0);
    checkOutput({name, "_beats"}, log_adr.size(), len + 1);
    for (int i = 0; i <= len && i < log_adr.size(); i++) begin
      checkOutput($sformatf("%s_adr%0d", name, i), log_adr[i], adr + 32'(4 * i));
      checkOutput($sformatf("%s_sel%0d", name, i), 32'(log_sel[i]), 32'(sel));
      checkOutput($sformatf("%s_we%0d", name, i), 32'(log_we[i]), 32'(is_write));
      if (is_write)
        checkOutput($sformatf("%s_wdat%0d", name, i), log_dat[i], wd_list[i]);
    end
    checkOutput({name, "_rcount"}, rdat_q.size(), is_write ? 0 : len + 1);
    if (!is_write) begin
      for (int i = 0; i <= len && i < rdat_q.size(); i++)
        checkOutput($sformatf("%s_rdat%0d", name, i), rdat_q[i], rd_list[i]);
    end
    checkOutput({name, "_stb_cycles"}, stb_cycles, (len + 1) * (wait_st + 1));
    exp_gap = len + 1;
    if (is_write && stall_beat >= 1 && stall_beat <= len) exp_gap += stall_cycles;
    checkOutput({name, "_gap_cycles"}, gap_cycles, exp_gap);
  endtask

  initial begin
    bit          rw;
    int          rlen;
    int          rws;
    int          rsb;
    int          rsc;
    int          cyc;
    int          ack0;
    logic [31:0] radr;
    logic [3:0]  rsel;

    repeat (2) @(negedge wb_clk_i);
    checkOutput("rst_cyc", 32'(bus.CYC_O), 0);
    checkOutput("rst_stb", 32'(bus.STB_O), 0);
    checkOutput("rst_we", 32'(bus.WE_O), 0);
    checkOutput("rst_adr", bus.ADR_O, 0);
    checkOutput("rst_sel", 32'(bus.SEL_O), 0);
    checkOutput("rst_busy", 32'(BUSY_O), 0);
    checkOutput("rst_done", 32'(DONE_O), 0);
    checkOutput("rst_err", 32'(ERR_O), 0);
    checkOutput("rst_ready", 32'(WDAT_READY_O), 0);
    checkOutput("rst_rvalid", 32'(RDAT_VALID_O), 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    $display("[TB] single write");
    wd_list = '{32'h0000_000C};
    rd_list.delete();
    applyStimulus(1'b1, 32'h3100_0000, 4'hF, 0, 1, -1, 0);
    checkBurst("wr1", 1'b1, 32'h3100_0000, 4'hF, 0, 1, -1, 0);

    $display("[TB] four-beat read");
    rd_list = '{32'h10, 32'h11, 32'h12, 32'h13};
    applyStimulus(1'b0, 32'h3100_0000, 4'hF, 3, 0, -1, 0);
    checkBurst("rd4", 1'b0, 32'h3100_0000, 4'hF, 3, 0, -1, 0);

    $display("[TB] write stall");
    wd_list = '{32'hA5A5_0001, 32'h5A5A_0002};
    rd_list.delete();
    applyStimulus(1'b1, 32'h3100_0100, 4'h3, 1, 0, 1, 5);
    checkBurst("wstall", 1'b1, 32'h3100_0100, 4'h3, 1, 0, 1, 5);

    $display("[TB] address wrap");
    rd_list = '{32'h1111_1111, 32'h2222_2222};
    applyStimulus(1'b0, 32'hFFFF_FFFC, 4'hF, 1, 1, -1, 0);
    checkBurst("wrap", 1'b0, 32'hFFFF_FFFC, 4'hF, 1, 1, -1, 0);
    checkOutput("wrap_adr1_zero", (log_adr.size() > 1) ? log_adr[1] : 32'hFFFF_FFFF, 0);

    $display("[TB] ack timeout");
    slave_mute = 1'b1;
    rd_list.delete();
    applyStimulus(1'b0, 32'h2000_0000, 4'hF, 3, 0, -1, 0);
    checkOutput("to_bound", 32'(timed_out), 0);
    checkOutput("to_err", err_cnt - err0, 1);
    checkOutput("to_done", done_cnt - done0, 0);
    checkOutput("to_stb_cycles", stb_cycles, TIMEOUT);
    checkOutput("to_cyc", 32'(bus.CYC_O), 0);
    checkOutput("to_busy", 32'(BUSY_O), 0);
    checkOutput("to_rcount", rdat_q.size(), 0);
    slave_mute = 1'b0;
    rd_list = '{32'hCAFE_0001, 32'hCAFE_0002};
    applyStimulus(1'b0, 32'h2000_0040, 4'h1, 1, 2, -1, 0);
    checkBurst("after_to", 1'b0, 32'h2000_0040, 4'h1, 1, 2, -1, 0);

    $display("[TB] random bursts");
    for (int n = 0; n < 10; n++) begin
      rw   = 1'($urandom_range(0, 1));
      radr = $urandom;
      rsel = 4'($urandom_range(1, 15));
      rlen = int'($urandom_range(0, MAX_BURST - 1));
      rws  = int'($urandom_range(0, 3));
      rsb  = rw ? int'($urandom_range(0, rlen)) : -1;
      rsc  = int'($urandom_range(0, 4));
      wd_list.delete();
      rd_list.delete();
      for (int i = 0; i <= rlen; i++) begin
        wd_list.push_back($urandom);
        rd_list.push_back($urandom);
      end
      if (rw) rd_list.delete();
      applyStimulus(rw, radr, rsel, rlen, rws, rsb, rsc);
      checkBurst($sformatf("rnd%0d", n), rw, radr, rsel, rlen, rws, rsb, rsc);
    end

    $display("[TB] reset mid-burst");
    rd_list.delete();
    for (int i = 0; i < 8; i++) rd_list.push_back(32'h7000_0000 + 32'(i));
    rd_q       = rd_list;
    slave_wait = 2;
    done0      = done_cnt;
    err0       = err_cnt;
    ack0       = ack_cnt;
    @(negedge wb_clk_i);
    READ_I = 1'b1;
    ADR_I  = 32'h4000_0000;
    SEL_I  = 4'hF;
    LEN_I  = 4'd7;
    @(negedge wb_clk_i);
    READ_I = 1'b0;
    cyc = 0;
    while (!((ack_cnt - ack0) >= 1 && bus.STB_O) && cyc < BOUND) begin
      @(negedge wb_clk_i);
      cyc++;
    end
    checkOutput("mid_reached_beat2", 32'(cyc < BOUND), 1);
    wb_rst_i = 1'b1;
    #1;
    checkOutput("mid_cyc", 32'(bus.CYC_O), 0);
    checkOutput("mid_stb", 32'(bus.STB_O), 0);
    checkOutput("mid_busy", 32'(BUSY_O), 0);
    checkOutput("mid_we", 32'(bus.WE_O), 0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    checkOutput("mid_no_done", done_cnt - done0, 0);
    checkOutput("mid_no_err", err_cnt - err0, 0);
    checkOutput("mid_idle_busy", 32'(BUSY_O), 0);
    rd_q.delete();

    rd_list = '{32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002};
    applyStimulus(1'b0, 32'h4000_0000, 4'hC, 2, 0, -1, 0);
    checkBurst("after_rst", 1'b0, 32'h4000_0000, 4'hC, 2, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_manager.md
Name: wb_burst_manager

Overview:
Parametrised next-generation Wishbone bus manager. Converts a single CPU-side command into a 1..MAX_BURST beat classic Wishbone cycle with incrementing addresses, streamed write/read data, and an ACK timeout watchdog. It sits between a CPU/requester and the wishbone_arbitrator, and supports configurable data and address widths.

Parameters:
DATA_W, 32, Wishbone data width in bits; multiple of 8.
ADDR_W, 32, address width in bits.
MAX_BURST, 16, maximum beats per command; power of 2, >= 1.
TIMEOUT, 64, max cycles STB_O may wait for ACK_I; 0 disables the watchdog.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous reset, active-high
WRITE_I  in  1  start write command (sampled in IDLE)
READ_I  in  1  start read command (sampled in IDLE)
ADR_I  in  ADDR_W  start byte address
SEL_I  in  DATA_W/8  byte lane select, applied to every beat
LEN_I  in  $clog2(MAX_BURST)  beats minus 1 (max(1,...) width when MAX_BURST=1)
CPU_DAT_I  in  DATA_W  write beat data
WDAT_VALID_I  in  1  CPU_DAT_I valid
WDAT_READY_O  out  1  manager accepts write beat
CPU_DAT_O  out  DATA_W  read beat data
RDAT_VALID_O  out  1  one-cycle pulse, CPU_DAT_O valid
BUSY_O  out  1  command in progress
DONE_O  out  1  one-cycle pulse, burst completed
ERR_O  out  1  one-cycle pulse, burst aborted by timeout
ADR_O  out  ADDR_W  Wishbone address
DAT_O  out  DATA_W  Wishbone write data
SEL_O  out  DATA_W/8  Wishbone select
WE_O  out  1  Wishbone write enable
STB_O  out  1  Wishbone strobe
CYC_O  out  1  Wishbone cycle
DAT_I  in  DATA_W  Wishbone read data
ACK_I  in  1  Wishbone acknowledge

Behaviour:
- All outputs registered. Reset (async, immediate): state IDLE, every output 0, counters 0; an in-flight burst is dropped with no DONE_O or ERR_O.
- States: IDLE, WDATA, STROBE, GAP, FINISH.
- IDLE: BUSY_O=0. At a rising edge with WRITE_I or READ_I high, latch ADR_I/SEL_I/LEN_I, set WE_O=WRITE_I (WRITE_I wins if both are high), beat=0, BUSY_O=1. Go to WDATA if write, STROBE if read. Commands arriving while BUSY_O=1 are ignored.
- WDATA: CYC_O held (0 on first beat), STB_O=0, WDAT_READY_O=1. On WDAT_VALID_I: DAT_O<=CPU_DAT_I, WDAT_READY_O<=0, go STROBE. Stall is unbounded; the timer does not run.
- STROBE: CYC_O=1, STB_O=1, ADR_O/SEL_O/WE_O stable. Timer increments each cycle without ACK_I.
  - On ACK_I: timer<=0, STB_O<=0. If read, CPU_DAT_O<=DAT_I and RDAT_VALID_O=1 for the next cycle.
  - If beat==LEN: go FINISH.
  - Otherwise: beat++, ADR_O += DATA_W/8 (mod 2^ADDR_W, wraps silently), go WDATA (write) or GAP (read). CYC_O stays 1 between beats.
- GAP: one cycle with STB_O=0, CYC_O=1, then STROBE.
- Timeout: TIMEOUT!=0 and timer reaches TIMEOUT-1 without ACK_I gives CYC_O<=0, STB_O<=0, ERR_O=1 pulse, go IDLE. An ACK_I in that same cycle takes priority; no error.
- FINISH: CYC_O<=0, WE_O<=0, DONE_O=1 pulse, BUSY_O<=0, go IDLE.
- Latency: a single-beat read with zero-wait ACK gives command edge → STB_O high +1 cycle → ACK → RDAT_VALID_O/DONE pipeline; DONE_O asserts 2 cycles after ACK.
- ACK_I outside STROBE is ignored.

Test Plan:
- Single write: ADR_I=0x31000000, LEN_I=0, CPU_DAT_I=0x0000000C, slave ACKs after 1 wait state → one STB with DAT_O=0xC, WE_O=1, SEL_O=0xF; DONE_O pulses once; BUSY_O then returns low.
- 4-beat read: ADR_I=0x31000000, LEN_I=3, slave returns 0x10..0x13 → ADR_O steps 0x31000000/04/08/0C; 4 RDAT_VALID_O pulses carrying 0x10..0x13; CYC_O continuous, STB_O low one cycle between beats.
- Write stall: LEN_I=1, WDAT_VALID_I withheld 5 cycles before the second beat → STB_O low and CYC_O high during the stall; no ERR_O; DONE_O asserts after the second ACK.
- Timeout: TIMEOUT=8, ACK_I tied 0 → STB_O high exactly 8 cycles, then CYC_O=0 and ERR_O pulses once, with no DONE_O; a new read is then accepted.
- Address wrap: ADDR_W=32, ADR_I=0xFFFFFFFC, LEN_I=1 → second beat ADR_O=0x00000000.
- Reset mid-burst: assert wb_rst_i during beat 2 of an 8-beat read → CYC_O/STB_O/BUSY_O drop immediately, with no DONE_O or ERR_O.
